// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, FSM encoding and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_RED  = 8'h1b;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_RED : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box as inverse (x^254, zero maps to zero) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq, inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_add_round_key.sv
// AddRoundKey: bytewise XOR of state and round key.
module aes_add_round_key (
  input  logic [127:0] i_st,
  input  logic [127:0] i_rk,
  output logic [127:0] o_st
);

  assign o_st = i_st ^ i_rk;

endmodule

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: next round key from current key and rcon.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_n
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3, w_t, w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = rk;

  assign w_t = {sbox(w_w3[23:16]) ^ rcon, sbox(w_w3[15:8]),
                sbox(w_w3[7:0]), sbox(w_w3[31:24])};

  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;
  assign rk_n = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_mix_columns.sv
// MixColumns: each 4-byte column multiplied by the fixed {02,03,01,01} circulant.
module aes_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] i_st,
  output logic [127:0] o_st
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign {w_a0, w_a1, w_a2, w_a3} = i_st[127-32*c -: 32];
    assign o_st[127-32*c -: 32] = {
      xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
      w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
      w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
      xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)};
  end

endmodule

// File: rtl/aes_shift_rows.sv
// ShiftRows: row r of the column-major state rotates left by r bytes.
module aes_shift_rows (
  input  logic [127:0] i_st,
  output logic [127:0] o_st
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign o_st[127-8*(4*c+r) -: 8] = i_st[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end

endmodule

// File: rtl/aes_sub_bytes.sv
// SubBytes: S-box applied to each of the 16 state bytes.
module aes_sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] i_st,
  output logic [127:0] o_st
);

  for (genvar b = 0; b < 16; b++) begin : g_byte
    assign o_st[8*b +: 8] = sbox(i_st[8*b +: 8]);
  end

endmodule

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encryptor, one round per clock on a shared round datapath.
// Optional AES_KEY_HOLD_EN adds key_reuse and a retained initial-key register.
module aes_iter_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef AES_KEY_HOLD_EN
  input  logic         key_reuse,
`endif
  input  logic [127:0] g_input,
  input  logic [127:0] e_input,
  output logic [127:0] o,
  output logic         busy,
  output logic         done
);

  state_t       r_state, w_state_n;
  logic [127:0] r_st, r_rk, r_o;
  logic [3:0]   r_rnd;
  logic [7:0]   r_rcon;
  logic         r_busy, r_done;

  logic [127:0] w_st_n, w_rkr_n, w_o_n;
  logic [3:0]   w_rnd_n;
  logic [7:0]   w_rcon_n;
  logic         w_busy_n, w_done_n;

  logic [127:0] w_rk_step, w_sb, w_sr, w_mc, w_mix_sel, w_ark, w_key_init;
  logic         w_last;

`ifdef AES_KEY_HOLD_EN
  logic [127:0] r_key0, w_key0_n;
  assign w_key_init = key_reuse ? r_key0 : g_input;
`else
  assign w_key_init = g_input;
`endif

  aes_key_step      u_key (.rk(r_rk), .rcon(r_rcon), .rk_n(w_rk_step));
  aes_sub_bytes     u_sb  (.i_st(r_st), .o_st(w_sb));
  aes_shift_rows    u_sr  (.i_st(w_sb), .o_st(w_sr));
  aes_mix_columns   u_mc  (.i_st(w_sr), .o_st(w_mc));
  aes_add_round_key u_ark (.i_st(w_mix_sel), .i_rk(w_rk_step), .o_st(w_ark));

  // Final round bypasses MixColumns
  assign w_last    = (r_rnd == 4'(NR));
  assign w_mix_sel = w_last ? w_sr : w_mc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_st    <= '0;
      r_rk    <= '0;
      r_o     <= '0;
      r_rnd   <= '0;
      r_rcon  <= RCON_INIT;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef AES_KEY_HOLD_EN
      r_key0  <= '0;
`endif
    end else begin
      r_state <= w_state_n;
      r_st    <= w_st_n;
      r_rk    <= w_rkr_n;
      r_o     <= w_o_n;
      r_rnd   <= w_rnd_n;
      r_rcon  <= w_rcon_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
`ifdef AES_KEY_HOLD_EN
      r_key0  <= w_key0_n;
`endif
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_st_n    = r_st;
    w_rkr_n   = r_rk;
    w_o_n     = r_o;
    w_rnd_n   = r_rnd;
    w_rcon_n  = r_rcon;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
`ifdef AES_KEY_HOLD_EN
    w_key0_n  = r_key0;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_st_n    = e_input ^ w_key_init;
          w_rkr_n   = w_key_init;
          w_rnd_n   = 4'd1;
          w_rcon_n  = RCON_INIT;
          w_busy_n  = 1'b1;
          w_state_n = RUN;
`ifdef AES_KEY_HOLD_EN
          w_key0_n  = w_key_init;
`endif
        end
      end
      RUN: begin
        w_rkr_n  = w_rk_step;
        w_rnd_n  = r_rnd + 4'd1;
        w_rcon_n = xtime(r_rcon);
        if (w_last) begin
          w_o_n     = w_ark;
          w_done_n  = 1'b1;
          w_busy_n  = 1'b0;
          w_state_n = IDLE;
        end else begin
          w_st_n = w_ark;
        end
      end
    endcase
  end

  assign o    = r_o;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Scoreboard bench for aes_iter_ctrl: expected ciphertexts queued at stimulus,
// popped and compared by a monitor on each done pulse.
module tb_aes_iter_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] g_input = '0;
  logic [127:0] e_input = '0;
  logic [127:0] o;
  logic         busy, done;
`ifdef AES_KEY_HOLD_EN
  logic         key_reuse = 1'b0;
`endif

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int bcount = 0;
  logic [127:0] exp_q[$];
  int done_cyc[$];

  aes_iter_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef AES_KEY_HOLD_EN
    .key_reuse(key_reuse),
`endif
    .g_input(g_input), .e_input(e_input),
    .o(o), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s: done not seen within 40 cycles, got 0 expected 1", nm);
    end
  endtask

  task automatic run_job(input logic [127:0] k, input logic [127:0] p, input logic [127:0] c);
    g_input = k;
    e_input = p;
    start = 1'b1;
    exp_q.push_back(c);
    tick();
    start = 1'b0;
    chk("busy_after_accept", 128'(busy), 128'd1);
  endtask

  // Monitor: busy-length tracking and ciphertext scoreboard
  always @(negedge clk) begin
    if (rst) bcount = 0;
    else if (busy) bcount++;
    if (done === 1'b1) begin
      done_cyc.push_back(cyc);
      total++;
      if (bcount != 10) begin
        bad++;
        $display("FAIL busy_len: got %0d cycles expected 10", bcount);
      end
      bcount = 0;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got o=%h expected no completion", o);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL ciphertext: got %h expected %h", o, e);
        end
      end
    end
  end

`ifdef AES_KEY_HOLD_EN
  // Independent byte-level reference, S-box built from log/antilog tables
  logic [7:0] exp_t[256];
  logic [7:0] log_t[256];
  logic [7:0] sb_t[256];

  function automatic logic [7:0] m_xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] p, v;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = p;
      log_t[p] = 8'(i);
      p = p ^ m_xt(p);
    end
    for (int b = 0; b < 256; b++) begin
      v = (b == 0) ? 8'h00 : exp_t[(255 - int'(log_t[b])) % 255];
      sb_t[b] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] s[16], t[16], k[16], tmp[4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) t[4*c+j] = s[4*((c+j)%4)+j];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gm2(a0) ^ gm2(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm2(a1) ^ gm2(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm2(a2) ^ gm2(a3) ^ a3;
          s[4*c+3] = gm2(a0) ^ a0 ^ a1 ^ a2 ^ gm2(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      tmp[0] = sb_t[k[13]] ^ rc; tmp[1] = sb_t[k[14]];
      tmp[2] = sb_t[k[15]];      tmp[3] = sb_t[k[12]];
      for (int j = 0; j < 4; j++) k[j] = k[j] ^ tmp[j];
      for (int j = 4; j < 16; j++) k[j] = k[j] ^ k[j-4];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
      rc = m_xt(rc);
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return m_xt(b);
  endfunction
`endif

  initial begin
    int n0;
    // Reset state
    tick();
    tick();
    chk("reset_o", o, '0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 128'(busy), 128'd0);

    // Vector 1
    run_job(K1, P1, C1);
    wait_done("vec1");
    tick();
    chk("done_pulse_width", 128'(done), 128'd0);
    chk("o_hold", o, C1);

    // Vector 2 with inputs scrambled after accept
    run_job(K2, P2, C2);
    for (int i = 0; i < 5; i++) begin
      g_input = {$urandom, $urandom, $urandom, $urandom};
      e_input = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    wait_done("vec2");

    // start held high for 30 cycles: three back-to-back jobs
    tick();
    done_cyc.delete();
    g_input = K1;
    e_input = P1;
    start = 1'b1;
    repeat (3) exp_q.push_back(C1);
    repeat (30) tick();
    start = 1'b0;
    wait_done("held_third");
    tick();
    chk("held_count", 128'(done_cyc.size()), 128'd3);
    if (done_cyc.size() == 3) begin
      chk("held_gap1", 128'(done_cyc[1] - done_cyc[0]), 128'd11);
      chk("held_gap2", 128'(done_cyc[2] - done_cyc[1]), 128'd11);
    end
    chk("held_o", o, C1);

    // start pulse while busy is ignored
    n0 = done_cyc.size();
    run_job(K1, P1, C1);
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_start_job");
    repeat (15) tick();
    chk("no_extra_job", 128'(done_cyc.size() - n0), 128'd1);
    chk("idle_after_ignore", 128'(busy), 128'd0);

    // Reset mid-operation
    n0 = done_cyc.size();
    g_input = K1;
    e_input = P1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_o", o, '0);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    repeat (15) tick();
    chk("abort_no_done", 128'(done_cyc.size() - n0), 128'd0);
    run_job(K2, P2, C2);
    wait_done("after_abort");
    tick();

    // rst and start together
    rst = 1'b1;
    start = 1'b1;
    tick();
    chk("rst_start_busy", 128'(busy), 128'd0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_start_busy2", 128'(busy), 128'd0);
    chk("rst_start_o", o, '0);

`ifdef AES_KEY_HOLD_EN
    build_sbox();
    key_reuse = 1'b0;
    run_job(K2, P2, C2);
    wait_done("hold_load");
    tick();
    key_reuse = 1'b1;
    run_job(128'h0, P1, model(K2, P1));
    key_reuse = 1'b0;
    wait_done("hold_reuse");
    tick();
`endif

    repeat (3) tick();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
